// File: rtl/sdpb_tap_sequencer_if.sv
// sdpb_tap_sequencer_if: sample input, RAM port pair and tap output of the tap sequencer.
// Latency: none, wires only.
// Backpressure: s_valid/s_ready on the sample side; the tap stream is not backpressured.
//
// Signals
//   s_valid/s_ready/s_data   sample handshake into the controller
//   ram_ada/ram_din/ram_cea  RAM write port (driven by the controller)
//   ram_adb/ram_ceb/ram_oce  RAM read port (driven by the controller)
//   ram_dout                 RAM read data (driven by the RAM)
//   tap_*                    tap stream towards the MAC
//   busy                     controller is not idle
//
// Modports
//   master : the controller (sdpb_tap_sequencer)
//   slave  : the surrounding logic (sample source, RAM, MAC)

interface sdpb_tap_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 18
);

   // sample input
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   // RAM write port
   logic [ADDR_W-1:0] ram_ada;
   logic [DATA_W-1:0] ram_din;
   logic              ram_cea;

   // RAM read port
   logic [ADDR_W-1:0] ram_adb;
   logic              ram_ceb;
   logic              ram_oce;
   logic [DATA_W-1:0] ram_dout;

   // tap stream
   logic              tap_valid;
   logic [DATA_W-1:0] tap_data;
   logic [ADDR_W-1:0] tap_idx;
   logic              tap_first;
   logic              tap_last;

   // status
   logic              busy;

   modport master (
      input  s_valid, s_data, ram_dout,
      output s_ready,
      output ram_ada, ram_din, ram_cea,
      output ram_adb, ram_ceb, ram_oce,
      output tap_valid, tap_data, tap_idx, tap_first, tap_last,
      output busy
   );

   modport slave (
      output s_valid, s_data, ram_dout,
      input  s_ready,
      input  ram_ada, ram_din, ram_cea,
      input  ram_adb, ram_ceb, ram_oce,
      input  tap_valid, tap_data, tap_idx, tap_first, tap_last,
      input  busy
   );

endinterface : sdpb_tap_sequencer_if

// File: rtl/sdpb_tap_sequencer.sv
// sdpb_tap_sequencer: ring-buffer delay line controller for one simple-dual-port RAM; writes
// Latency: each sample then reads NTAPS taps newest-first. Accept cycle -> tap 0 valid 3 cycles later.
// Backpressure: s_ready only in IDLE, so one sample per NTAPS+3 cycles; tap stream has no backpressure.
//
// Ports
//   clk    single clock for the controller and both RAM ports
//   reset  synchronous, active-high; restarts the zero-fill and drops in-flight taps
//   bus    sdpb_tap_sequencer_if.master: sample handshake, RAM ports, tap stream, busy
//
// Sequence per sample: IDLE (accept) -> WRITE (1) -> READ (NTAPS) -> DRAIN (1) -> IDLE.
// After reset the whole ring is written with zeros (CLEAR) so taps older than the
// number of samples written read as 0.

module sdpb_tap_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 18,
   parameter int NTAPS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   sdpb_tap_sequencer_if.master  bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   generate
      if (NTAPS < 1 || NTAPS > DEPTH) begin : g_bad_ntaps
         $error("sdpb_tap_sequencer: NTAPS must lie in 1..2**ADDR_W");
      end
   endgenerate

   // Terminal counts. k and clr_cnt carry one extra bit so a full-depth count fits.
   localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   K_LAST   = (ADDR_W+1)'(NTAPS - 1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NTAPS - 1);

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN
   } state_t;

   // Registered tap-side state, one bundle per returning read.
   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] idx;
   } tap_t;

   state_t            state_q;
   state_t            state_d;

   logic [ADDR_W:0]   clr_cnt_q;   // zero-fill address counter
   logic [ADDR_W-1:0] wr_ptr_q;    // ring slot the next sample goes to
   logic [ADDR_W-1:0] base_q;      // slot of the sample currently being processed
   logic [DATA_W-1:0] smp_q;       // sample held between accept and WRITE
   logic [ADDR_W:0]   k_q;         // tap counter during READ
   tap_t              tap_q;

   // Combinational decode of the registered state.
   logic              s_ready_c;
   logic              cea_c;
   logic [ADDR_W-1:0] ada_c;
   logic [DATA_W-1:0] din_c;
   logic              ceb_c;
   logic [ADDR_W-1:0] adb_c;
   logic              busy_c;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         wr_ptr_q  <= '0;
         base_q    <= '0;
         smp_q     <= '0;
         k_q       <= '0;
         tap_q     <= '0;
      end else begin
         state_q <= state_d;

         // The RAM returns data one cycle after a read-enable cycle, so the tap
         // qualifiers are simply the READ decode and k delayed by one cycle.
         tap_q.vld <= (state_q == ST_READ);
         tap_q.idx <= k_q[ADDR_W-1:0];

         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + CNT_ONE;
            end
            ST_IDLE: begin
               if (bus.s_valid) begin
                  smp_q  <= bus.s_data;
                  base_q <= wr_ptr_q;
               end
            end
            ST_WRITE: begin
               k_q <= '0;
            end
            ST_READ: begin
               k_q <= k_q + CNT_ONE;
            end
            ST_DRAIN: begin
               // The pointer only advances once all taps of this sample are read,
               // so base_q and wr_ptr_q agree again by the next accept.
               wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Next state and RAM/handshake decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      s_ready_c = 1'b0;
      cea_c     = 1'b0;
      ada_c     = '0;
      din_c     = '0;
      ceb_c     = 1'b0;
      adb_c     = '0;
      busy_c    = 1'b1;

      case (state_q)
         ST_CLEAR: begin
            cea_c = 1'b1;
            ada_c = clr_cnt_q[ADDR_W-1:0];
            if (clr_cnt_q == CLR_LAST) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            busy_c    = 1'b0;
            s_ready_c = 1'b1;
            if (bus.s_valid) begin
               state_d = ST_WRITE;
            end
         end

         ST_WRITE: begin
            // Written one edge before the first read, so tap 0 is the new sample
            // without relying on RAM read-during-write behaviour.
            cea_c   = 1'b1;
            ada_c   = base_q;
            din_c   = smp_q;
            state_d = ST_READ;
         end

         ST_READ: begin
            // Walk backwards from the newest slot; the subtraction wraps around the ring.
            ceb_c = 1'b1;
            adb_c = base_q - k_q[ADDR_W-1:0];
            if (k_q == K_LAST) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Idle RAM cycle while the last tap comes back.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.s_ready   = s_ready_c;
   assign bus.busy      = busy_c;

   assign bus.ram_cea   = cea_c;
   assign bus.ram_ada   = ada_c;
   assign bus.ram_din   = din_c;
   assign bus.ram_ceb   = ceb_c;
   assign bus.ram_adb   = adb_c;
   assign bus.ram_oce   = 1'b1;   // RAM runs in bypass read mode

   assign bus.tap_valid = tap_q.vld;
   assign bus.tap_idx   = tap_q.idx;
   assign bus.tap_data  = bus.ram_dout;
   assign bus.tap_first = tap_q.vld && (tap_q.idx == '0);
   assign bus.tap_last  = tap_q.vld && (tap_q.idx == IDX_LAST);

endmodule : sdpb_tap_sequencer

// File: tb/tb_sdpb_tap_sequencer.sv
// tb_sdpb_tap_sequencer: directed bench for the tap sequencer in NTAPS=4, 16 and 1 builds.
// Latency: each DUT sees a one-cycle registered RAM model on its read port.
// Backpressure: the sample source waits on s_ready, bounded by a cycle budget.

module tb_sdpb_tap_sequencer;

   localparam int AW = 8;
   localparam int DW = 18;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   bit mon_en = 1'b0;

   sdpb_tap_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 (), bus16 (), bus1 ();

   sdpb_tap_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NTAPS(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));
   sdpb_tap_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NTAPS(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
   sdpb_tap_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NTAPS(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));

   // Simple-dual-port RAMs, read data one cycle after a read-enable cycle.
   logic [DW-1:0] mem4 [256];
   logic [DW-1:0] mem16 [256];
   logic [DW-1:0] mem1 [256];

   always @(posedge clk) begin
      if (bus4.ram_cea)  mem4[bus4.ram_ada]   <= bus4.ram_din;
      if (bus4.ram_ceb)  bus4.ram_dout        <= mem4[bus4.ram_adb];
      if (bus16.ram_cea) mem16[bus16.ram_ada] <= bus16.ram_din;
      if (bus16.ram_ceb) bus16.ram_dout       <= mem16[bus16.ram_adb];
      if (bus1.ram_cea)  mem1[bus1.ram_ada]   <= bus1.ram_din;
      if (bus1.ram_ceb)  bus1.ram_dout        <= mem1[bus1.ram_adb];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] tapv(input logic v, input logic f, input logic l,
                                        input logic [AW-1:0] idx, input logic [DW-1:0] d);
      return {35'd0, v, f, l, idx, d};
   endfunction

   // Port exclusivity and idle-zero addressing on every cycle once reset has been applied.
   always @(negedge clk) begin
      if (mon_en) begin
         check("ram_excl4", 64'(!(bus4.ram_cea && bus4.ram_ceb) &&
                                (bus4.ram_cea || (bus4.ram_ada == '0 && bus4.ram_din == '0)) &&
                                (bus4.ram_ceb || bus4.ram_adb == '0) && bus4.ram_oce), 64'd1);
         check("ram_excl16", 64'(!(bus16.ram_cea && bus16.ram_ceb) &&
                                 (bus16.ram_ceb || bus16.ram_adb == '0)), 64'd1);
      end
   end

   task automatic wait_ready4();
      int n = 0;
      while (!bus4.s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready4_timeout", 64'(bus4.s_ready), 64'd1);
   endtask

   // One full sample on the NTAPS=4 build: accept, WRITE, 4 READs, DRAIN.
   task automatic run_burst4(input logic [DW-1:0] v, input logic [AW-1:0] base,
                             input logic [3:0][DW-1:0] e,
                             output logic [3:0][AW-1:0] adbs, output logic [3:0][DW-1:0] got);
      wait_ready4();
      bus4.s_valid = 1'b1;
      bus4.s_data  = v;
      @(negedge clk);
      bus4.s_valid = 1'b0;
      check("write", {bus4.ram_cea, bus4.ram_ceb, bus4.ram_ada, bus4.ram_din, bus4.s_ready, bus4.busy},
            {1'b1, 1'b0, base, v, 1'b0, 1'b1});
      for (int t = 0; t <= 4; t++) begin
         @(negedge clk);
         if (t < 4) begin
            adbs[t] = bus4.ram_adb;
            check("read", {bus4.ram_cea, bus4.ram_ceb, bus4.ram_adb}, {1'b0, 1'b1, base - AW'(t)});
         end else begin
            check("drain", {bus4.ram_cea, bus4.ram_ceb, bus4.s_ready, bus4.busy}, {1'b0, 1'b0, 1'b0, 1'b1});
         end
         if (t == 0) begin
            check("tap_latency", 64'(bus4.tap_valid), 64'd0);
         end else begin
            got[t-1] = bus4.tap_data;
            check("tap", tapv(bus4.tap_valid, bus4.tap_first, bus4.tap_last, bus4.tap_idx, bus4.tap_data),
                  tapv(1'b1, t == 1, t == 4, AW'(t - 1), e[t-1]));
         end
      end
   endtask

   initial begin
      #300us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a16 [3];
      int a1 [3];
      int c16;
      int c1;
      int tv16;
      int tv1;
      logic [3:0][DW-1:0] e;
      logic [3:0][DW-1:0] got;
      logic [3:0][AW-1:0] adbs;
      logic [DW-1:0] want3 [4];
      logic [AW-1:0] want_adb [4];
      logic [DW-1:0] want_d [4];

      c16 = 0; c1 = 0; tv16 = 0; tv1 = 0;
      bus4.s_valid = 1'b0;  bus4.s_data = '0;
      bus16.s_valid = 1'b0; bus16.s_data = '0;
      bus1.s_valid = 1'b0;  bus1.s_data = '0;

      // ---- reset and zero-fill ----
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(bus4.s_ready), 64'd0);
      check("rst_tapv", 64'(bus4.tap_valid), 64'd0);
      check("rst_busy", 64'(bus4.busy), 64'd1);
      mon_en = 1'b1;
      reset  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         check("clear", {bus4.ram_cea, bus4.ram_ada, bus4.ram_din, bus4.s_ready, bus4.busy},
               {1'b1, 8'(i), 18'd0, 1'b0, 1'b1});
         @(negedge clk);
      end
      check("clear_done4", {bus4.s_ready, bus4.busy, bus4.ram_cea}, {1'b1, 1'b0, 1'b0});
      check("clear_done16", {bus16.s_ready, bus16.busy, bus16.ram_cea}, {1'b1, 1'b0, 1'b0});
      check("clear_done1", {bus1.s_ready, bus1.busy, bus1.ram_cea}, {1'b1, 1'b0, 1'b0});

      // ---- s_valid held high: cadence on NTAPS=16 and NTAPS=1 builds ----
      bus16.s_data = 18'h2A5A5; bus16.s_valid = 1'b1;
      bus1.s_data  = 18'h00155; bus1.s_valid  = 1'b1;
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (bus16.s_ready) begin
            if (c16 < 3) a16[c16] = cyc;
            c16++;
         end
         if (bus1.s_ready) begin
            if (c1 < 3) a1[c1] = cyc;
            c1++;
         end
         if (bus16.tap_valid) begin
            if (c16 == 2) tv16++;
            // only the first c16 ring slots have been written since the clear
            check("tap16_data", 64'(bus16.tap_data), (int'(bus16.tap_idx) < c16) ? 64'h2A5A5 : 64'd0);
         end
         if (bus1.tap_valid) begin
            if (c1 == 2) tv1++;
            check("tap1", {bus1.tap_first, bus1.tap_last, bus1.tap_idx, bus1.tap_data},
                  {1'b1, 1'b1, 8'd0, 18'h00155});
         end
         @(negedge clk);
      end
      bus16.s_valid = 1'b0;
      bus1.s_valid  = 1'b0;
      check("acc16_first", 64'(a16[0]), 64'd0);
      check("acc16_gap1", 64'(a16[1] - a16[0]), 64'd19);
      check("acc16_gap2", 64'(a16[2] - a16[1]), 64'd19);
      check("acc16_count", 64'(c16), 64'd3);
      check("taps16_per_sample", 64'(tv16), 64'd16);
      check("acc1_gap1", 64'(a1[1] - a1[0]), 64'd4);
      check("acc1_gap2", 64'(a1[2] - a1[1]), 64'd4);
      check("acc1_count", 64'(c1), 64'd13);
      check("taps1_per_sample", 64'(tv1), 64'd1);

      // ---- NTAPS=4: samples n=1..258 written to slot n-1 ----
      want3    = '{18'd3, 18'd2, 18'd1, 18'd0};
      want_adb = '{8'd1, 8'd0, 8'd255, 8'd254};
      want_d   = '{18'd258, 18'd257, 18'd256, 18'd255};
      for (int n = 1; n <= 258; n++) begin
         for (int j = 0; j < 4; j++) e[j] = (n > j) ? DW'(n - j) : '0;
         run_burst4(DW'(n), AW'(n - 1), e, adbs, got);
         if (n == 3) begin
            for (int j = 0; j < 4; j++) check("third_burst", 64'(got[j]), 64'(want3[j]));
         end
         if (n == 258) begin
            for (int j = 0; j < 4; j++) begin
               check("last_adb", 64'(adbs[j]), 64'(want_adb[j]));
               check("last_data", 64'(got[j]), 64'(want_d[j]));
            end
         end
      end

      // ---- reset during the third READ cycle ----
      wait_ready4();
      bus4.s_valid = 1'b1;
      bus4.s_data  = 18'h3C3C3;
      @(negedge clk);
      bus4.s_valid = 1'b0;
      check("mid_write", {bus4.ram_cea, bus4.ram_ada}, {1'b1, 8'd2});
      repeat (3) @(negedge clk);
      check("mid_read2", {bus4.ram_ceb, bus4.ram_adb}, {1'b1, 8'd0});
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_tapv", 64'(bus4.tap_valid), 64'd0);
      check("mid_rst_state", {bus4.ram_cea, bus4.ram_ada, bus4.ram_ceb, bus4.s_ready, bus4.busy},
            {1'b1, 8'd0, 1'b0, 1'b0, 1'b1});
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         check("reclear", {bus4.ram_cea, bus4.ram_ada, bus4.tap_valid}, {1'b1, 8'(i), 1'b0});
         @(negedge clk);
      end
      // wr_ptr restarts at 0 and the ring is zero again behind the new sample
      run_burst4(18'h12345, 8'd0, {18'd0, 18'd0, 18'd0, 18'h12345}, adbs, got);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_sdpb_tap_sequencer
